// File: rtl/mux_2.sv
// Registered bit-wise 2:1 multiplexer: each bit of c_o picks b_i where select_i
// is 1 and a_i where it is 0, held in a one-entry valid/ready output stage.
`timescale 1ns/1ps
module mux_2 #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic [width_p-1:0] select_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [width_p-1:0] c_o,
  output logic               valid_o,
  input  logic               ready_i
);

  logic [width_p-1:0] r_c;
  logic               r_valid;
  logic [width_p-1:0] w_mux;
  logic               w_accept;

  // Pure AND/OR form keeps each output bit dependent only on its own three inputs.
  assign w_mux    = (select_i & b_i) | (~select_i & a_i);
  assign ready_o  = ~r_valid | ready_i;
  assign w_accept = valid_i & ready_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_c     <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_c     <= w_mux;
        r_valid <= 1'b1;
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign c_o     = r_c;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_mux_2.sv
// Randomised scoreboard bench for mux_2 (width 8): a reference model queues
// expected beats on acceptance and a negedge monitor checks every output.
`timescale 1ns/1ps
module tb_mux_2;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         reset_ni = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0, select_i = '0;
  logic         valid_i = 1'b0, ready_i = 1'b1;
  logic         ready_o, valid_o;
  logic [W-1:0] c_o;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic         model_valid = 1'b0;
  logic [W-1:0] model_c = '0;

  mux_2 #(.width_p(W)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .a_i(a_i), .b_i(b_i),
    .select_i(select_i), .valid_i(valid_i), .ready_o(ready_o),
    .c_o(c_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_mux(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] s);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = s[k] ? b[k] : a[k];
    return r;
  endfunction

  // Reference model: a one-slot holding stage described by occupancy and contents.
  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      model_valid <= 1'b0;
      model_c     <= '0;
      exp_q.delete();
    end else if (valid_i && (!model_valid || ready_i)) begin
      exp_q.push_back(ref_mux(a_i, b_i, select_i));
      model_c     <= ref_mux(a_i, b_i, select_i);
      model_valid <= 1'b1;
    end else if (ready_i) begin
      model_valid <= 1'b0;
    end
  end

  // Monitor: state checks every cycle, transaction check on each output handshake.
  always @(negedge clk_i) begin
    check("valid_o", 32'(valid_o), 32'(model_valid));
    check("ready_o", 32'(ready_o), 32'(!model_valid || ready_i));
    check("c_o_hold", 32'(c_o), 32'(model_c));
    if (reset_ni && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: output beat %0h with nothing expected at %0t", c_o, $time);
      end else begin
        check("c_o_beat", 32'(c_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s,
                       input logic v, input logic r);
    @(posedge clk_i);
    #1;
    a_i = a; b_i = b; select_i = s; valid_i = v; ready_i = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b1);
  endtask

  initial begin
    logic [2:0] combo;
    logic [W-1:0] ra, rb, rs;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_c", 32'(c_o), 32'd0);
    reset_ni = 1'b1;

    // Exhaustive single-bit combinations on bit 0 (upper bits random)
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      ra = W'($urandom); rb = W'($urandom); rs = W'($urandom);
      ra[0] = combo[0]; rb[0] = combo[1]; rs[0] = combo[2];
      drive(ra, rb, rs, 1'b1, 1'b1);
    end
    idle(1);
    check("bit0_last", 32'(c_o[0]), 32'd1);

    // Per-bit select
    drive(8'hF0, 8'h3C, 8'hAA, 1'b1, 1'b1);
    idle(1);
    #1 check("perbit_78", 32'(c_o), 32'h78);
    idle(1);

    // Backpressure: hold for 3 cycles with new inputs offered, then drain
    drive(8'h11, 8'hEE, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0);
    #1 check("stall_c", 32'(c_o), 32'h11);
    check("stall_ready", 32'(ready_o), 32'd0);
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    idle(1);
    #1 check("drained_valid", 32'(valid_o), 32'd0);
    // Stall then release with a simultaneous new beat
    drive(8'h22, 8'h00, 8'h00, 1'b1, 1'b0);
    drive(8'h33, 8'h00, 8'h00, 1'b1, 1'b0);
    drive(8'h44, 8'h00, 8'h00, 1'b1, 1'b1);
    idle(1);
    #1 check("refill_c", 32'(c_o), 32'h44);

    // Back-to-back stream
    for (int i = 1; i <= 4; i++) drive(W'(i), 8'hFF, 8'h00, 1'b1, 1'b1);
    idle(2);

    // Async reset between edges with a held 0xFF beat
    drive(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk_i);
    #2 reset_ni = 1'b0;
    #1;
    check("async_valid", 32'(valid_o), 32'd0);
    check("async_c", 32'(c_o), 32'd0);
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    drive(8'h5A, 8'hA5, 8'h0F, 1'b1, 1'b1);
    idle(1);
    #1 check("post_reset_c", 32'(c_o), 32'h55);

    // valid_i=0 with toggling data must leave outputs untouched
    for (int i = 0; i < 4; i++) drive(W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'(i & 1));
    #1 check("idle_c", 32'(c_o), 32'h55);

    // Random traffic
    for (int i = 0; i < 300; i++)
      drive(W'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0));
    idle(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_2.md
Name: mux_2

Overview:
- Registered, bit-wise 2:1 multiplexer with a one-entry valid/ready output stage.
- Each output bit independently selects between the corresponding bits of two input words under a per-bit select word.
- Used as a generic datapath steering element. The output register decouples the combinational select path from downstream logic.

Parameters:
- width_p, default 1, width in bits of a_i, b_i, select_i and c_o; legal range 1..1024.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- reset_ni  input  1  asynchronous active-low reset
- a_i  input  width_p  data word selected where select bit = 0
- b_i  input  width_p  data word selected where select bit = 1
- select_i  input  width_p  per-bit select
- valid_i  input  1  a_i/b_i/select_i carry a valid beat
- ready_o  output  1  block can accept a beat this cycle
- c_o  output  width_p  registered mux result
- valid_o  output  1  c_o holds a valid result
- ready_i  input  1  downstream accepts c_o this cycle

Behaviour:
- Mux function, bit-wise, for every k in 0..width_p-1:
  - c_o[k] = select_i[k] ? b_i[k] : a_i[k].
  - No cross-bit interaction.
- The selected word is computed combinationally from the inputs and captured into a width_p-bit output register.
- Reset: reset_ni low asynchronously forces valid_o = 0 and c_o = 0, regardless of clk_i.
  - Release is sampled on the next rising edge.
  - Reset mid-transfer discards the held beat.
- ready_o = ~valid_o | ready_i. This is combinational from ready_i and state; there is no path from valid_i to ready_o.
- Input accept: valid_i & ready_o at a rising edge.
  - Loads the mux result into c_o.
  - Sets valid_o = 1.
- Output drain: valid_o & ready_i at a rising edge with no accept clears valid_o. c_o keeps its last value.
- Simultaneous drain and accept in one cycle: the new result is loaded and valid_o stays 1. Full throughput is one beat per cycle.
- Stall: valid_o & ~ready_i holds c_o and valid_o stable. The inputs are ignored because ready_o = 0.
- Latency: a result appears on c_o in the cycle after the accepting edge.
- c_o changes only on an accept edge or reset. Inputs while valid_i = 0 never affect c_o.
- X/Z on select_i propagates per-bit. No special X handling is required.

Test Plan:
- Exhaustive width_p=1, ready_i=1: all 8 combinations of (a_i, b_i, select_i), each with valid_i=1.
  - Select=0 cases: (0,0,0)->0, (1,0,0)->1, (0,1,0)->0, (1,1,0)->1.
  - Select=1 cases: (0,0,1)->0, (1,0,1)->0, (0,1,1)->1, (1,1,1)->1.
  - Each result appears on c_o one cycle after acceptance, with valid_o=1.
- Per-bit select, width_p=8: a_i=8'hF0, b_i=8'h3C, select_i=8'hAA -> c_o=8'h78.
- Backpressure:
  - Accept a_i=8'h11, select_i=0. Hold ready_i=0 for 3 cycles: c_o stays 8'h11, valid_o stays 1, ready_o stays 0, and new inputs are ignored.
  - Raise ready_i: valid_o drops next cycle unless a new beat arrives in the same cycle.
- Back-to-back throughput, ready_i=1:
  - Stream 4 beats with a_i = 1, 2, 3, 4 and select_i=0.
  - c_o shows 1, 2, 3, 4 on consecutive cycles; ready_o stays 1 throughout.
- Async reset mid-operation:
  - With valid_o=1 and c_o=8'hFF, pull reset_ni low between clock edges.
  - valid_o=0 and c_o=0 take effect immediately.
  - After release, the first accepted beat behaves normally.
- valid_i=0 with changing a_i/b_i/select_i: c_o and valid_o remain unchanged.
